// File: rtl/first_signal_detector_n.sv
// ---------------------------------------------------------------------------
// first_signal_detector_n
//   N-channel, re-armable first-arrival detector. After an arm request it
//   watches the channels, captures which one(s) hit first, locks that result
//   and offers it through a valid/ack handshake. It also reports the
//   arm-to-hit latency and an optional window timeout.
//
// Parameters
//   N_CH       number of monitored channels (>= 2)
//   CNT_W      width of the latency counter, elapsed and timeout_lim
//   EDGE_MODE  0: a channel hits while high; 1: only on a 0->1 edge
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   arm          request a new detection window
//   sig          monitored channels
//   timeout_lim  window length in cycles, 0 disables the timeout
//   ack          consumer accepts the current result
//   busy         high while a window is open (ARMED)
//   valid        result available (LOCKED or TIMEOUT)
//   lock_mask    channels that hit on the capture cycle
//   winner_idx   lowest set bit of lock_mask
//   tie          more than one bit set in lock_mask
//   elapsed      ARMED cycles before the hit, or timeout_lim on timeout
//   timed_out    window expired with no hit
//
// Build option
//   FSD_INPUT_SYNC_EN  when defined, sig passes through a 2-flop synchroniser
//                      before the hit logic (capture latency +2 cycles).
// ---------------------------------------------------------------------------
module first_signal_detector_n #(
    parameter int N_CH      = 3,
    parameter int CNT_W     = 16,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      arm,
    input  logic [N_CH-1:0]                           sig,
    input  logic [CNT_W-1:0]                          timeout_lim,
    input  logic                                      ack,
    output logic                                      busy,
    output logic                                      valid,
    output logic [N_CH-1:0]                           lock_mask,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] winner_idx,
    output logic                                      tie,
    output logic [CNT_W-1:0]                          elapsed,
    output logic                                      timed_out
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [N_CH-1:0]  CH_ONE  = N_CH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LOCKED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [N_CH-1:0]  sig_s;
    logic [N_CH-1:0]  sig_q;
    logic [N_CH-1:0]  hit;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_found;
    logic             hit_multi;
    logic             window_end;

`ifdef FSD_INPUT_SYNC_EN
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig;
            sync2 <= sync1;
        end
    end

    assign sig_s = sync2;
`else
    assign sig_s = sig;
`endif

    // Previous-cycle copy runs in every state so that a channel already high
    // when the window opens does not count as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_s;
        end
    end

    assign hit = EDGE_MODE ? (sig_s & ~sig_q) : sig_s;

    // x & (x-1) clears the lowest set bit; anything left means a tie.
    assign hit_multi  = |(hit & (hit - CH_ONE));
    assign window_end = (timeout_lim != '0) && (counter == timeout_lim - CNT_ONE);

    always_comb begin
        hit_idx   = '0;
        hit_found = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (hit[i] && !hit_found) begin
                hit_idx   = IDX_W'(i);
                hit_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            lock_mask  <= '0;
            winner_idx <= '0;
            tie        <= 1'b0;
            elapsed    <= '0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        state      <= ARMED;
                        counter    <= '0;
                        busy       <= 1'b1;
                        valid      <= 1'b0;
                        lock_mask  <= '0;
                        winner_idx <= '0;
                        tie        <= 1'b0;
                        elapsed    <= '0;
                        timed_out  <= 1'b0;
                    end
                end

                ARMED: begin
                    if (hit != '0) begin
                        // A hit takes priority over a timeout on the same cycle.
                        state      <= LOCKED;
                        busy       <= 1'b0;
                        valid      <= 1'b1;
                        lock_mask  <= hit;
                        winner_idx <= hit_idx;
                        tie        <= hit_multi;
                        elapsed    <= counter;
                    end else if (window_end) begin
                        state      <= TIMEOUT;
                        busy       <= 1'b0;
                        valid      <= 1'b1;
                        timed_out  <= 1'b1;
                        lock_mask  <= '0;
                        elapsed    <= timeout_lim;
                    end else if (counter != '1) begin
                        counter <= counter + CNT_ONE;
                    end
                end

                LOCKED, TIMEOUT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        if (arm) begin
                            state      <= ARMED;
                            counter    <= '0;
                            busy       <= 1'b1;
                            lock_mask  <= '0;
                            winner_idx <= '0;
                            tie        <= 1'b0;
                            elapsed    <= '0;
                            timed_out  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_first_signal_detector_n.sv
// ---------------------------------------------------------------------------
// tb_first_signal_detector_n
//   Directed bench for first_signal_detector_n: a table of single-window
//   vectors plus hand sequences for sticky lock, handshake, reset and edge
//   mode. A level-mode and an edge-mode instance share the input stimulus.
// ---------------------------------------------------------------------------
module tb_first_signal_detector_n;

`ifdef FSD_INPUT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic [2:0]  sig = '0;
    logic [15:0] timeout_lim = '0;
    logic        ack = 1'b0;

    logic        busy, valid, tie, timed_out;
    logic [2:0]  lock_mask;
    logic [1:0]  winner_idx;
    logic [15:0] elapsed;

    logic        busy_e, valid_e, tie_e, timed_out_e;
    logic [2:0]  lock_mask_e;
    logic [1:0]  winner_idx_e;
    logic [15:0] elapsed_e;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    first_signal_detector_n #(.N_CH(3), .CNT_W(16), .EDGE_MODE(1'b0)) dut (
        .clk(clk), .rst(rst), .arm(arm), .sig(sig), .timeout_lim(timeout_lim),
        .ack(ack), .busy(busy), .valid(valid), .lock_mask(lock_mask),
        .winner_idx(winner_idx), .tie(tie), .elapsed(elapsed), .timed_out(timed_out)
    );

    first_signal_detector_n #(.N_CH(3), .CNT_W(16), .EDGE_MODE(1'b1)) dut_e (
        .clk(clk), .rst(rst), .arm(arm), .sig(sig), .timeout_lim(timeout_lim),
        .ack(ack), .busy(busy_e), .valid(valid_e), .lock_mask(lock_mask_e),
        .winner_idx(winner_idx_e), .tie(tie_e), .elapsed(elapsed_e), .timed_out(timed_out_e)
    );

    typedef struct {
        logic [2:0]  pattern;  // sig value once the hit cycle is reached
        int          hit_cyc;  // window cycle where pattern is first driven
        logic [15:0] lim;
        logic [2:0]  mask;     // expected capture if the hit wins
        logic [1:0]  idx;
        logic        tie;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arm = 1'b0;
        ack = 1'b0;
        sig = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Idle with sig low (flushes any synchroniser history), arm, then drive
    // the pattern from hit_cyc onward until valid rises or the budget runs out.
    task automatic run_window(input logic [2:0] pattern, input int hit_cyc,
                              input logic [15:0] lim, output int cycles);
        sig = '0;
        timeout_lim = lim;
        tick();
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("busy_after_arm", {31'd0, busy}, 32'd1);
        cycles = 0;
        while (!valid && cycles < 64) begin
            sig = (cycles >= hit_cyc) ? pattern : 3'b000;
            tick();
            cycles++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        int   cycles;
        int   k_eff;
        logic is_hit;
        logic [2:0]  held_mask;

        vecs[0] = '{pattern: 3'b010, hit_cyc: 3, lim: 16'd0,  mask: 3'b010, idx: 2'd1, tie: 1'b0};
        vecs[1] = '{pattern: 3'b101, hit_cyc: 0, lim: 16'd0,  mask: 3'b101, idx: 2'd0, tie: 1'b1};
        vecs[2] = '{pattern: 3'b000, hit_cyc: 0, lim: 16'd5,  mask: 3'b000, idx: 2'd0, tie: 1'b0};
        vecs[3] = '{pattern: 3'b100, hit_cyc: 4, lim: 16'd5,  mask: 3'b100, idx: 2'd2, tie: 1'b0};
        vecs[4] = '{pattern: 3'b110, hit_cyc: 1, lim: 16'd10, mask: 3'b110, idx: 2'd1, tie: 1'b1};
        vecs[5] = '{pattern: 3'b011, hit_cyc: 2, lim: 16'd3,  mask: 3'b011, idx: 2'd0, tie: 1'b1};

        // Reset state
        #2;
        chk("reset_outputs",
            {8'd0, busy, valid, lock_mask, winner_idx, tie, elapsed, timed_out}, 32'd0);
        do_reset();
        chk("reset_outputs_post", {8'd0, busy, valid, lock_mask, winner_idx, tie, elapsed, timed_out}, 32'd0);

        // ack with nothing pending is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack_valid", {31'd0, valid}, 32'd0);
        chk("idle_ack_busy",  {31'd0, busy},  32'd0);

        // Table of single windows
        for (int v = 0; v < 6; v++) begin
            run_window(vecs[v].pattern, vecs[v].hit_cyc, vecs[v].lim, cycles);
            k_eff  = vecs[v].hit_cyc + SYNC_LAT;
            is_hit = (vecs[v].pattern != 3'b000) &&
                     ((vecs[v].lim == 16'd0) || (k_eff < int'(vecs[v].lim)));
            chk($sformatf("v%0d_latency", v), cycles,
                is_hit ? k_eff + 1 : int'(vecs[v].lim));
            chk($sformatf("v%0d_valid", v), {31'd0, valid}, 32'd1);
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("v%0d_mask", v), {29'd0, lock_mask}, is_hit ? {29'd0, vecs[v].mask} : 32'd0);
            chk($sformatf("v%0d_idx", v), {30'd0, winner_idx}, is_hit ? {30'd0, vecs[v].idx} : 32'd0);
            chk($sformatf("v%0d_tie", v), {31'd0, tie}, is_hit ? {31'd0, vecs[v].tie} : 32'd0);
            chk($sformatf("v%0d_elapsed", v), {16'd0, elapsed},
                is_hit ? k_eff : {16'd0, vecs[v].lim});
            chk($sformatf("v%0d_timed_out", v), {31'd0, timed_out}, is_hit ? 32'd0 : 32'd1);
            held_mask = lock_mask;
            sig = '0;
            do_ack();
            chk($sformatf("v%0d_ack_valid", v), {31'd0, valid}, 32'd0);
            chk($sformatf("v%0d_ack_retained", v), {29'd0, lock_mask},
                is_hit ? {29'd0, vecs[v].mask} : 32'd0);
            chk($sformatf("v%0d_ack_busy", v), {31'd0, busy}, 32'd0);
            if (held_mask !== lock_mask) begin
                tests++;
                failed++;
                $display("FAIL v%0d_ack_hold: got 0x%0h expected 0x%0h", v, lock_mask, held_mask);
            end
        end

        // Sticky lock: later activity and a lone arm leave the result alone
        run_window(3'b010, 3, 16'd0, cycles);
        sig = 3'b111;
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        chk("sticky_valid",   {31'd0, valid}, 32'd1);
        chk("sticky_busy",    {31'd0, busy}, 32'd0);
        chk("sticky_mask",    {29'd0, lock_mask}, 32'b010);
        chk("sticky_idx",     {30'd0, winner_idx}, 32'd1);
        chk("sticky_tie",     {31'd0, tie}, 32'd0);
        chk("sticky_elapsed", {16'd0, elapsed}, 3 + SYNC_LAT);

        // ack + arm together re-arms directly with cleared results
        sig = '0;
        ack = 1'b1;
        arm = 1'b1;
        tick();
        ack = 1'b0;
        arm = 1'b0;
        chk("rearm_busy",    {31'd0, busy}, 32'd1);
        chk("rearm_valid",   {31'd0, valid}, 32'd0);
        chk("rearm_results", {11'd0, lock_mask, winner_idx, tie, elapsed, timed_out}, 32'd0);

        // Reset mid-window returns to IDLE immediately, no clock needed
        tick();
        tick();
        chk("window_open", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            {8'd0, busy, valid, lock_mask, winner_idx, tie, elapsed, timed_out}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("after_reset_idle", {30'd0, busy, valid}, 32'd0);

        // Edge mode: a channel already high at arm time never hits
        do_reset();
        timeout_lim = 16'd0;
        sig = 3'b100;
        tick();
        tick();
        tick();
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("edge_busy", {31'd0, busy_e}, 32'd1);
        cycles = 0;
        while (!valid_e && cycles < 64) begin
            sig = (cycles >= 2) ? 3'b101 : 3'b100;
            tick();
            cycles++;
        end
        chk("edge_latency", cycles, 3 + SYNC_LAT);
        chk("edge_mask",    {29'd0, lock_mask_e}, 32'b001);
        chk("edge_idx",     {30'd0, winner_idx_e}, 32'd0);
        chk("edge_tie",     {31'd0, tie_e}, 32'd0);
        chk("edge_elapsed", {16'd0, elapsed_e}, 2 + SYNC_LAT);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
